urv_dm_wb_bridge: RTL and testbench
===================================

Name: urv_dm_wb_bridge

Overview:
Data-memory bus adapter directly downstream of the uRV CPU's data memory port. It turns the CPU's single-cycle load/store request pulses into pipelined Wishbone B4 master cycles. It returns the completion pulses and load data the writeback stage consumes. It adds a bus-timeout watchdog and error capture so a dead slave cannot hang the core.

Parameters:
g_timeout_cycles, 255, cycles waiting for ack/err before forced completion; 0 disables the watchdog.
g_err_load_value, 32'hDEADBEEF, value returned on dm_data_l_o for a failed or timed-out load.

Ports:
clk_i  in  1  clock.
rst_n_i  in  1  asynchronous active-low reset.
dm_addr_i  in  32  byte address from CPU.
dm_data_s_i  in  32  store data.
dm_data_select_i  in  4  byte lane enables.
dm_store_i  in  1  store request pulse.
dm_load_i  in  1  load request pulse.
dm_ready_o  out  1  bridge idle; can accept a request this cycle.
dm_data_l_o  out  32  load data, valid while dm_load_done_o=1.
dm_load_done_o  out  1  one-cycle load completion pulse.
dm_store_done_o  out  1  one-cycle store completion pulse.
wb_adr_o  out  32  Wishbone address (word-aligned: bits [1:0] forced 0).
wb_dat_o  out  32  Wishbone write data.
wb_sel_o  out  4  Wishbone select.
wb_we_o  out  1  write enable.
wb_cyc_o  out  1  cycle.
wb_stb_o  out  1  strobe.
wb_dat_i  in  32  read data.
wb_ack_i  in  1  acknowledge.
wb_err_i  in  1  bus error.
wb_stall_i  in  1  pipelined stall.
bus_err_o  out  1  one-cycle pulse on err or timeout.
bus_err_addr_o  out  32  address of the last failed access; holds until the next error.

Behaviour:
- Reset, asynchronous on rst_n_i low: all outputs 0 except dm_ready_o=1. State=IDLE. Any bus cycle in flight is abandoned immediately: cyc/stb drop with no completion pulse.
- States: IDLE, STROBE, WAIT_ACK, DONE.
- IDLE:
  - dm_ready_o=1.
  - A request is dm_load_i or dm_store_i high. Both high together: store wins, and the load is dropped.
  - On a request, register adr/dat/sel/we. Next cycle: cyc=stb=1, dm_ready_o=0, state STROBE.
- STROBE:
  - stb held until a cycle with wb_stall_i=0. Then stb=0 next cycle and state WAIT_ACK; cyc stays 1.
  - ack/err arriving while stb=1 and stall=0 goes straight to DONE.
- WAIT_ACK: wait for wb_ack_i or wb_err_i.
  - On ack: latch wb_dat_i for a load.
  - On err: load data = g_err_load_value; pulse bus_err_o and capture bus_err_addr_o.
  - ack and err in the same cycle: treat as err.
- Timeout:
  - Counter starts at the first STROBE cycle and counts STROBE and WAIT_ACK cycles.
  - At count == g_timeout_cycles: handled as err and cyc/stb dropped. Ack arriving that same cycle still counts as err.
  - Counter width is clog2(g_timeout_cycles+1).
- DONE:
  - Lasts exactly one cycle, with cyc=stb=0.
  - dm_load_done_o or dm_store_done_o =1 for that one cycle; dm_data_l_o valid with it.
  - Next cycle IDLE, dm_ready_o=1.
- Latency: request at cycle N with zero-wait slave (ack in the first STROBE cycle) → stb at N+1, done pulse at N+2, ready at N+3.
- Requests while dm_ready_o=0 are ignored. The CPU guarantees none; assertion required in the bench.
- dm_data_l_o resets to 0 and otherwise holds its value between loads. Store completion leaves it unchanged.
- Late ack/err arriving in IDLE after a timeout is ignored.

Decomposition:
- State encoding constants and the default error-load value go in urv_defs.v.
- One sub-module, urv_bus_watchdog: loadable cycle counter with enable/clear/expired, parameterised by g_timeout_cycles.
- Everything else is one flat FSM.

Test Plan:
- Load addr 0x1004, slave acks in the first STROBE cycle with 0xCAFEBABE → dm_load_done_o pulses at N+2 with data 0xCAFEBABE; wb_sel_o matches the request; dm_ready_o is back at N+3.
- Store 0x12345678, sel 4'b0011, addr 0x2002, stall held 3 cycles → wb_adr_o=0x2000, wb_we_o=1, stb held 4 cycles, one dm_store_done_o pulse after ack.
- Load with wb_err_i instead of ack at addr 0x3000 → dm_load_done_o with 0xDEADBEEF, bus_err_o pulse, bus_err_addr_o=0x3000.
- g_timeout_cycles=8, slave never responds → forced done with 0xDEADBEEF after 8 bus cycles; a late ack 3 cycles after that produces no extra pulse.
- dm_load_i and dm_store_i high together → exactly one write cycle and only dm_store_done_o.
- rst_n_i low while in WAIT_ACK → cyc/stb drop asynchronously, no done pulse, dm_ready_o=1; the next request completes normally.

Source files
------------

// File: rtl/urv_dm_wb_bridge_pkg.sv
// rtl/urv_dm_wb_bridge_pkg.sv - shared types and constants for the uRV data-memory Wishbone bridge
package urv_dm_wb_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_STROBE   = 2'd1,
    ST_WAIT_ACK = 2'd2,
    ST_DONE     = 2'd3
  } bridge_state_t;

  localparam logic [31:0] C_ERR_LOAD_VALUE = 32'hDEADBEEF;

  // Wishbone is word addressed; byte position is carried by the select lanes.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/urv_bus_watchdog.sv
// rtl/urv_bus_watchdog.sv - saturating bus-cycle counter that flags a stuck Wishbone access
module urv_bus_watchdog #(
  parameter int g_timeout_cycles = 255
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic load_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int          W       = (g_timeout_cycles > 0) ? $clog2(g_timeout_cycles + 1) : 1;
  localparam logic [W-1:0] LIMIT  = W'(g_timeout_cycles);
  localparam logic [W-1:0] ONE    = W'(1);
  localparam bit          ENABLED = (g_timeout_cycles > 0);

  logic [W-1:0] count;
  logic         at_limit;

  assign at_limit = (count == LIMIT);

  // Loading 1 makes the count equal the number of the bus cycle in progress.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      count <= '0;
    end else if (load_i) begin
      count <= ONE;
    end else if (en_i && !at_limit) begin
      count <= count + ONE;
    end
  end

  assign expired_o = ENABLED && en_i && at_limit;

endmodule

// File: rtl/urv_dm_wb_bridge.sv
// rtl/urv_dm_wb_bridge.sv - uRV data-memory port to pipelined Wishbone B4 master with timeout and error capture
module urv_dm_wb_bridge
  import urv_dm_wb_bridge_pkg::*;
#(
  parameter int          g_timeout_cycles = 255,
  parameter logic [31:0] g_err_load_value = C_ERR_LOAD_VALUE
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_data_s_i,
  input  logic [3:0]  dm_data_select_i,
  input  logic        dm_store_i,
  input  logic        dm_load_i,
  output logic        dm_ready_o,
  output logic [31:0] dm_data_l_o,
  output logic        dm_load_done_o,
  output logic        dm_store_done_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  input  logic        wb_stall_i,
  output logic        bus_err_o,
  output logic [31:0] bus_err_addr_o
);

  bridge_state_t state;

  logic request;
  logic in_bus;
  logic resp_valid;
  logic expired;
  logic finish;
  logic fail;

  assign request = dm_load_i || dm_store_i;
  assign in_bus  = (state == ST_STROBE) || (state == ST_WAIT_ACK);

  // A response only counts in STROBE once the slave has taken the strobe.
  assign resp_valid = (state == ST_WAIT_ACK) || !wb_stall_i;
  assign finish     = in_bus && (expired || (resp_valid && (wb_ack_i || wb_err_i)));
  assign fail       = expired || (resp_valid && wb_err_i);

  urv_bus_watchdog #(
    .g_timeout_cycles(g_timeout_cycles)
  ) u_watchdog (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .load_i   ((state == ST_IDLE) && request),
    .en_i     (in_bus),
    .expired_o(expired)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state           <= ST_IDLE;
      dm_ready_o      <= 1'b1;
      dm_data_l_o     <= '0;
      dm_load_done_o  <= 1'b0;
      dm_store_done_o <= 1'b0;
      wb_adr_o        <= '0;
      wb_dat_o        <= '0;
      wb_sel_o        <= '0;
      wb_we_o         <= 1'b0;
      wb_cyc_o        <= 1'b0;
      wb_stb_o        <= 1'b0;
      bus_err_o       <= 1'b0;
      bus_err_addr_o  <= '0;
    end else begin
      dm_load_done_o  <= 1'b0;
      dm_store_done_o <= 1'b0;
      bus_err_o       <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (request) begin
            wb_adr_o   <= word_align(dm_addr_i);
            wb_dat_o   <= dm_data_s_i;
            wb_sel_o   <= dm_data_select_i;
            wb_we_o    <= dm_store_i;
            wb_cyc_o   <= 1'b1;
            wb_stb_o   <= 1'b1;
            dm_ready_o <= 1'b0;
            state      <= ST_STROBE;
          end
        end

        ST_STROBE, ST_WAIT_ACK: begin
          if (finish) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            state    <= ST_DONE;
            if (wb_we_o) begin
              dm_store_done_o <= 1'b1;
            end else begin
              dm_load_done_o <= 1'b1;
              dm_data_l_o    <= fail ? g_err_load_value : wb_dat_i;
            end
            if (fail) begin
              bus_err_o      <= 1'b1;
              bus_err_addr_o <= wb_adr_o;
            end
          end else if ((state == ST_STROBE) && !wb_stall_i) begin
            wb_stb_o <= 1'b0;
            state    <= ST_WAIT_ACK;
          end
        end

        ST_DONE: begin
          dm_ready_o <= 1'b1;
          state      <= ST_IDLE;
        end

        default: begin
          wb_cyc_o   <= 1'b0;
          wb_stb_o   <= 1'b0;
          dm_ready_o <= 1'b1;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_urv_dm_wb_bridge.sv
// tb/tb_urv_dm_wb_bridge.sv - directed vector bench for urv_dm_wb_bridge
module tb_urv_dm_wb_bridge;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] dm_addr = '0;
  logic [31:0] dm_data_s = '0;
  logic [3:0]  dm_sel = '0;
  logic        dm_store = 1'b0;
  logic        dm_load = 1'b0;
  logic        dm_ready;
  logic [31:0] dm_data_l;
  logic        dm_load_done;
  logic        dm_store_done;
  logic [31:0] wb_adr;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel;
  logic        wb_we;
  logic        wb_cyc;
  logic        wb_stb;
  logic [31:0] wb_dat_i = '0;
  logic        wb_ack = 1'b0;
  logic        wb_err = 1'b0;
  logic        wb_stall = 1'b0;
  logic        bus_err;
  logic [31:0] bus_err_addr;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  urv_dm_wb_bridge #(
    .g_timeout_cycles(8),
    .g_err_load_value(32'hDEADBEEF)
  ) dut (
    .clk_i           (clk),
    .rst_n_i         (rst_n),
    .dm_addr_i       (dm_addr),
    .dm_data_s_i     (dm_data_s),
    .dm_data_select_i(dm_sel),
    .dm_store_i      (dm_store),
    .dm_load_i       (dm_load),
    .dm_ready_o      (dm_ready),
    .dm_data_l_o     (dm_data_l),
    .dm_load_done_o  (dm_load_done),
    .dm_store_done_o (dm_store_done),
    .wb_adr_o        (wb_adr),
    .wb_dat_o        (wb_dat_o),
    .wb_sel_o        (wb_sel),
    .wb_we_o         (wb_we),
    .wb_cyc_o        (wb_cyc),
    .wb_stb_o        (wb_stb),
    .wb_dat_i        (wb_dat_i),
    .wb_ack_i        (wb_ack),
    .wb_err_i        (wb_err),
    .wb_stall_i      (wb_stall),
    .bus_err_o       (bus_err),
    .bus_err_addr_o  (bus_err_addr)
  );

  always @(posedge clk) begin
    if (rst_n && !dm_ready)
      assert (!(dm_load || dm_store)) else $error("request issued while bridge busy");
  end

  typedef struct {
    logic        ld;
    logic        st;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [3:0]  sel;
    int          stall;
    int          delay;
    logic        ack;
    logic        err;
    logic [31:0] rdata;
    int          exp_done_k;
    logic        exp_we;
    logic [31:0] exp_adr;
    int          exp_stb;
    logic [31:0] exp_data_l;
    logic        exp_err;
    logic [31:0] exp_err_addr;
  } vec_t;

  vec_t vecs[8];

  function automatic vec_t mk(logic ld, logic st, logic [31:0] addr, logic [31:0] sdata,
                              logic [3:0] sel, int stall, int delay, logic ack, logic err,
                              logic [31:0] rdata, int exp_done_k, logic exp_we,
                              logic [31:0] exp_adr, int exp_stb, logic [31:0] exp_data_l,
                              logic exp_err, logic [31:0] exp_err_addr);
    vec_t v;
    v.ld = ld; v.st = st; v.addr = addr; v.sdata = sdata; v.sel = sel;
    v.stall = stall; v.delay = delay; v.ack = ack; v.err = err; v.rdata = rdata;
    v.exp_done_k = exp_done_k; v.exp_we = exp_we; v.exp_adr = exp_adr;
    v.exp_stb = exp_stb; v.exp_data_l = exp_data_l; v.exp_err = exp_err;
    v.exp_err_addr = exp_err_addr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Cycle k=0 is the request cycle; the slave model reacts to the strobe every cycle.
  task automatic run_vec(input int idx, input vec_t v);
    int stb_cnt = 0, done_k = -1, ld_cnt = 0, st_cnt = 0, err_cnt = 0;
    int acc_k = -1, stall_left = v.stall;
    logic [31:0] got_data = '0;
    logic seen_ready = 1'b0;
    logic ready_k1 = 1'b1;
    logic we_k1 = 1'b0;
    logic [31:0] adr_k1 = '0, dat_k1 = '0;
    logic [3:0] sel_k1 = '0;
    @(negedge clk);
    dm_addr = v.addr; dm_data_s = v.sdata; dm_sel = v.sel;
    dm_load = v.ld; dm_store = v.st;
    wb_dat_i = v.rdata;
    for (int k = 1; k <= 30 && !seen_ready; k++) begin
      @(negedge clk);
      dm_load = 1'b0; dm_store = 1'b0;
      if (k == 1) begin
        ready_k1 = dm_ready; we_k1 = wb_we; adr_k1 = wb_adr; sel_k1 = wb_sel; dat_k1 = wb_dat_o;
      end
      if (wb_stb) stb_cnt++;
      if (dm_load_done) begin ld_cnt++; got_data = dm_data_l; done_k = k; end
      if (dm_store_done) begin st_cnt++; done_k = k; end
      if (bus_err) err_cnt++;
      if (done_k > 0 && k == done_k + 1) begin
        seen_ready = 1'b1;
        chk($sformatf("v%0d ready_after_done", idx), {31'b0, dm_ready}, 32'd1);
        chk($sformatf("v%0d data_l_held", idx), dm_data_l, v.exp_data_l);
      end
      wb_ack = 1'b0; wb_err = 1'b0; wb_stall = 1'b0;
      if (wb_stb && acc_k < 0) begin
        if (stall_left > 0) begin wb_stall = 1'b1; stall_left--; end
        else acc_k = k;
      end
      if (acc_k >= 0 && k == acc_k + v.delay && wb_cyc) begin
        wb_ack = v.ack; wb_err = v.err;
      end
    end
    wb_ack = 1'b0; wb_err = 1'b0; wb_stall = 1'b0;
    if (!seen_ready) begin
      tests++; failed++;
      $display("FAIL v%0d completion_timeout: no done/ready within 30 cycles", idx);
    end
    chk($sformatf("v%0d ready_busy", idx), {31'b0, ready_k1}, 32'd0);
    chk($sformatf("v%0d wb_we", idx), {31'b0, we_k1}, {31'b0, v.exp_we});
    chk($sformatf("v%0d wb_adr", idx), adr_k1, v.exp_adr);
    chk($sformatf("v%0d wb_sel", idx), {28'b0, sel_k1}, {28'b0, v.sel});
    chk($sformatf("v%0d wb_dat", idx), dat_k1, v.sdata);
    chk($sformatf("v%0d stb_cycles", idx), stb_cnt, v.exp_stb);
    chk($sformatf("v%0d done_cycle", idx), done_k, v.exp_done_k);
    chk($sformatf("v%0d load_done_pulses", idx), ld_cnt, v.exp_we ? 0 : 1);
    chk($sformatf("v%0d store_done_pulses", idx), st_cnt, v.exp_we ? 1 : 0);
    chk($sformatf("v%0d bus_err_pulses", idx), err_cnt, {31'b0, v.exp_err});
    chk($sformatf("v%0d bus_err_addr", idx), bus_err_addr, v.exp_err_addr);
    if (!v.exp_we) chk($sformatf("v%0d load_data", idx), got_data, v.exp_data_l);
  endtask

  initial begin
    int pulses;
    vecs[0] = mk(1, 0, 32'h1004, 32'h0, 4'hF, 0, 0, 1, 0, 32'hCAFEBABE,
                 2, 0, 32'h1004, 1, 32'hCAFEBABE, 0, 32'h0);
    vecs[1] = mk(0, 1, 32'h2002, 32'h12345678, 4'b0011, 3, 1, 1, 0, 32'h0,
                 6, 1, 32'h2000, 4, 32'hCAFEBABE, 0, 32'h0);
    vecs[2] = mk(1, 0, 32'h3000, 32'h0, 4'hF, 0, 0, 0, 1, 32'h11111111,
                 2, 0, 32'h3000, 1, 32'hDEADBEEF, 1, 32'h3000);
    vecs[3] = mk(1, 0, 32'h4008, 32'h0, 4'b0100, 1, 2, 1, 0, 32'h0BADF00D,
                 5, 0, 32'h4008, 2, 32'h0BADF00D, 0, 32'h3000);
    vecs[4] = mk(1, 1, 32'h5000, 32'hA5A5A5A5, 4'hF, 0, 0, 1, 0, 32'h22222222,
                 2, 1, 32'h5000, 1, 32'h0BADF00D, 0, 32'h3000);
    vecs[5] = mk(1, 0, 32'h6001, 32'h0, 4'b0010, 0, 1, 1, 1, 32'h33333333,
                 3, 0, 32'h6000, 1, 32'hDEADBEEF, 1, 32'h6000);
    vecs[6] = mk(0, 1, 32'h8004, 32'h5555AAAA, 4'b1100, 100, 0, 1, 0, 32'h0,
                 9, 1, 32'h8004, 8, 32'hDEADBEEF, 1, 32'h8004);
    vecs[7] = mk(1, 0, 32'h7000, 32'h0, 4'hF, 0, 0, 0, 0, 32'h0,
                 9, 0, 32'h7000, 1, 32'hDEADBEEF, 1, 32'h7000);

    repeat (2) @(negedge clk);
    chk("reset ready", {31'b0, dm_ready}, 32'd1);
    chk("reset cyc_stb", {30'b0, wb_cyc, wb_stb}, 32'd0);
    chk("reset done", {30'b0, dm_load_done, dm_store_done}, 32'd0);
    chk("reset data_l", dm_data_l, 32'h0);
    chk("reset bus_err", {31'b0, bus_err}, 32'd0);
    chk("reset err_addr", bus_err_addr, 32'h0);
    chk("reset wb_adr", wb_adr, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // Late ack three cycles after the timeout completion must be ignored.
    @(negedge clk);
    @(negedge clk);
    wb_ack = 1'b1; wb_dat_i = 32'h44444444;
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      wb_ack = 1'b0;
      if (dm_load_done || dm_store_done || bus_err || wb_cyc || !dm_ready) pulses++;
    end
    chk("late_ack no_activity", pulses, 0);
    chk("late_ack data_l", dm_data_l, 32'hDEADBEEF);

    // Asynchronous reset while waiting for ack.
    @(negedge clk);
    dm_addr = 32'h9000; dm_sel = 4'hF; dm_load = 1'b1;
    @(negedge clk);
    dm_load = 1'b0;
    @(negedge clk);
    chk("arst pre wait_ack", {30'b0, wb_cyc, wb_stb}, 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst cyc_stb", {30'b0, wb_cyc, wb_stb}, 32'd0);
    chk("arst ready", {31'b0, dm_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (dm_load_done || dm_store_done || bus_err) pulses++;
    end
    chk("arst no_done", pulses, 0);
    run_vec(8, mk(1, 0, 32'hA00C, 32'h0, 4'b1000, 0, 0, 1, 0, 32'h76543210,
                  2, 0, 32'hA00C, 1, 32'h76543210, 0, 32'h0));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1, "bench time limit reached");
  end

endmodule
